// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a 16x-oversampled 8N1 UART transmitter (8E1/8O1 when UART_TX_PARITY_EN is defined).
// Latency: a byte pushed into an empty idle block drives the start bit two clocks later; line is registered.
// Backpressure: none; pushes while full are dropped and latch the sticky overflow flag until reset.
module uart_tx_fifo #(
   parameter int FIFO_AW    = 3,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       b_tick,
   input  logic       push,
   input  logic [7:0] push_data,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int DEPTH = 2 ** FIFO_AW;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   state_t             state;
   logic [7:0]         shreg;
   logic [2:0]         bit_cnt;
   logic [3:0]         tick_cnt;
   logic               do_push;
   logic               do_pop;
   logic               bit_end;

`ifdef UART_TX_PARITY_EN
   logic               par_bit;
`else
   // Parity sense has nothing to act on in a frame without a parity bit.
   logic               unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   // count tops out at DEPTH, so its MSB alone marks the full condition.
   assign full    = count[FIFO_AW];
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = (state == IDLE) && !empty;
   assign bit_end = b_tick && (tick_cnt == 4'd15) && (state != IDLE);
   assign tx_busy = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && full) begin
            overflow <= 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The line is registered from the current state, so it trails the FSM by one clock uniformly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         tick_cnt <= '0;
         uart_tx  <= 1'b1;
         tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         if ((state != IDLE) && b_tick) begin
            tick_cnt <= tick_cnt + 4'd1;
         end
         case (state)
            IDLE: begin
               uart_tx <= 1'b1;
               if (!empty) begin
                  shreg    <= mem[rd_ptr];
                  bit_cnt  <= '0;
                  tick_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                  par_bit  <= (^mem[rd_ptr]) ^ PARITY_ODD;
`endif
                  state    <= START;
               end
            end
            START: begin
               uart_tx <= 1'b0;
               if (bit_end) begin
                  state <= DATA;
               end
            end
            DATA: begin
               uart_tx <= shreg[0];
               if (bit_end) begin
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               uart_tx <= par_bit;
               if (bit_end) begin
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               uart_tx <= 1'b1;
               if (bit_end) begin
                  state   <= IDLE;
                  tx_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a 16x-oversampling line receiver decodes frames and
// checks bit timing, while a byte queue holds what should appear on the line, in order.
module tb_uart_tx_fifo;
   localparam int AW   = 3;
   localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_BUDGET = 1500;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       b_tick = 1'b0;
   logic       push = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       full, empty, overflow, uart_tx, tx_busy, tx_done;

   uart_tx_fifo #(.FIFO_AW(AW), .PARITY_ODD(PODD)) dut (
      .clk       (clk),
      .rst       (rst),
      .b_tick    (b_tick),
      .push      (push),
      .push_data (push_data),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      b_tick = ($urandom_range(0, 2) == 0);
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line receiver: a tick strobed during one clock is consumed at the next edge, and the
   // line shows that edge's bit one clock later, hence counting the previous clock's tick.
   int         cyc = 0;
   logic       prev_tick = 1'b0;
   logic       prev_line = 1'b1;
   bit         in_frame = 0;
   bit         have_end = 0;
   int         tcount = 0;
   int         end_cyc = 0;
   logic [10:0] fbits = '1;
   int         frame_cnt = 0, start_cnt = 0, done_cnt = 0;
   int         timing_err = 0, fmt_err = 0, done_err = 0;
   logic [7:0] rx_byte[$];
   logic       rx_par[$];
   int         rx_gap[$];

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0;
         have_end = 0;
      end else begin
         if (tx_done) done_cnt++;
         if (!in_frame) begin
            if (prev_line && !uart_tx) begin
               in_frame = 1;
               start_cnt++;
               tcount = prev_tick ? 1 : 0;
               fbits = '1;
               if (have_end) rx_gap.push_back(cyc - end_cyc);
               have_end = 0;
            end
         end else begin
            if ((uart_tx != prev_line) && ((tcount % 16) != 0)) timing_err++;
            if (prev_tick) begin
               tcount++;
               if ((tcount % 16) == 8) fbits[tcount / 16] = uart_tx;
               if (tcount == 16 * NBITS) begin
                  if (fbits[0] != 1'b0 || fbits[NBITS-1] != 1'b1) fmt_err++;
                  if (!tx_done) done_err++;
                  rx_byte.push_back(fbits[8:1]);
                  rx_par.push_back(fbits[9]);
                  frame_cnt++;
                  in_frame = 0;
                  have_end = 1;
                  end_cyc  = cyc;
               end
            end
         end
      end
      prev_tick = b_tick;
      prev_line = uart_tx;
      cyc++;
   end

   logic [7:0] exp_q[$];
   int         rx_idx = 0;
   int         exp_frames = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] b, input bit accepted);
      push = 1'b1;
      push_data = b;
      step();
      push = 1'b0;
      if (accepted) begin
         exp_q.push_back(b);
         exp_frames++;
      end
   endtask

   task automatic wait_frames();
      int n;
      int budget;
      n = 0;
      budget = (exp_frames - frame_cnt) * FRAME_BUDGET + 500;
      while (frame_cnt < exp_frames && n < budget) begin
         step();
         n++;
      end
      check("frame_count", frame_cnt, exp_frames);
      repeat (3) step();
   endtask

   task automatic check_rx();
      logic [7:0] e;
      while (exp_q.size() > 0 && rx_idx < rx_byte.size()) begin
         e = exp_q.pop_front();
         check("rx_byte", rx_byte[rx_idx], e);
`ifdef UART_TX_PARITY_EN
         check("parity_bit", rx_par[rx_idx], (^e) ^ PODD);
`endif
         rx_idx++;
      end
      check("bytes_missing", exp_q.size(), 0);
      check("tx_done_count", done_cnt, exp_frames);
      check("bit_timing", timing_err, 0);
      check("start_stop", fmt_err, 0);
      check("done_at_stop", done_err, 0);
      check("drained_empty", empty, 1'b1);
      check("drained_busy", tx_busy, 1'b0);
   endtask

   task automatic check_gaps(input int n);
      check("gap_entries", (rx_gap.size() >= n - 1) ? 1 : 0, 1);
      if (rx_gap.size() >= n - 1) begin
         for (int k = 0; k < n - 1; k++) begin
            check("b2b_gap", rx_gap[rx_gap.size() - 1 - k], 2);
         end
      end
   endtask

   initial begin
      int n;
      int frames_snap, starts_snap, dones_snap, low_cnt, done_seen;

      step();
      step();
      check("rst_line", uart_tx, 1'b1);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      rst = 1'b0;

      // Single 0x55 frame plus first-byte latency.
      push_one(8'h55, 1);
      check("lat_e0_empty", empty, 1'b0);
      check("lat_e0_line", uart_tx, 1'b1);
      step();
      check("lat_e1_line", uart_tx, 1'b1);
      check("lat_e1_busy", tx_busy, 1'b1);
      step();
      check("lat_e2_line", uart_tx, 1'b0);
      wait_frames();
      check_rx();

      // Two back-to-back frames with opposite parity.
      push_one(8'hA5, 1);
      push_one(8'h07, 1);
      wait_frames();
      check_rx();
      check_gaps(2);

      // Ten consecutive pushes: one lands in the shifter, eight fill the FIFO, the tenth drops.
      for (int i = 0; i < 10; i++) begin
         push_one(8'($urandom), i < 9);
         if (i == 8) begin
            check("ovf_full_at9", full, 1'b1);
            check("ovf_flag_at9", overflow, 1'b0);
         end
      end
      check("ovf_full_at10", full, 1'b1);
      check("ovf_flag_at10", overflow, 1'b1);
      wait_frames();
      check_rx();
      check_gaps(9);
      check("ovf_sticky", overflow, 1'b1);

      // Push coinciding with a pop while four bytes are queued.
      for (int i = 0; i < 5; i++) push_one(8'($urandom), 1);
      n = 0;
      while (!tx_done && n < 2 * FRAME_BUDGET) begin
         step();
         n++;
      end
      check("pp_done_seen", tx_done, 1'b1);
      push_one(8'($urandom), 1);
      check("pp_empty", empty, 1'b0);
      check("pp_full", full, 1'b0);
      for (int i = 0; i < 3; i++) push_one(8'($urandom), 1);
      check("pp_full_at7", full, 1'b0);
      push_one(8'($urandom), 1);
      check("pp_full_at8", full, 1'b1);
      wait_frames();
      check_rx();
      check_gaps(10);

      // Reset in the middle of the data bits with three bytes waiting.
      check("pre_rst_overflow", overflow, 1'b1);
      for (int i = 0; i < 4; i++) push_one(8'($urandom), 0);
      n = 0;
      while (!(in_frame && tcount >= 40) && n < 2 * FRAME_BUDGET) begin
         step();
         n++;
      end
      check("rst_reached_data", (in_frame && tcount >= 40) ? 1 : 0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_line", uart_tx, 1'b1);
      check("mid_rst_empty", empty, 1'b1);
      check("mid_rst_overflow", overflow, 1'b0);
      check("mid_rst_busy", tx_busy, 1'b0);
      check("mid_rst_done", tx_done, 1'b0);
      frames_snap = frame_cnt;
      starts_snap = start_cnt;
      dones_snap  = done_cnt;
      low_cnt = 0;
      done_seen = 0;
      repeat (400) begin
         step();
         if (!uart_tx) low_cnt++;
         if (tx_done) done_seen++;
      end
      check("post_rst_low", low_cnt, 0);
      check("post_rst_done", done_seen, 0);
      check("post_rst_frames", frame_cnt, frames_snap);
      check("post_rst_starts", start_cnt, starts_snap);
      check("post_rst_done_cnt", done_cnt, dones_snap);
      check("post_rst_empty", empty, 1'b1);

      // Random bytes at random spacing, never more than four outstanding.
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 200)) step();
         n = 0;
         while ((exp_frames - frame_cnt) >= 4 && n < 2 * FRAME_BUDGET) begin
            step();
            n++;
         end
         push_one(8'($urandom), 1);
      end
      wait_frames();
      check_rx();
      check("rand_overflow", overflow, 1'b0);
      check("rand_full", full, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter: FIFO_AW, default 3, FIFO address width; depth = 2**FIFO_AW bytes.
REQ-002 SHALL have parameter: PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: b_tick  input  1  16x-oversample baud strobe, one clk wide.
REQ-006 SHALL have port: push  input  1  write strobe for push_data.
REQ-007 SHALL have port: push_data  input  8  byte to queue.
REQ-008 SHALL have port: full  output  1  FIFO holds 2**FIFO_AW entries.
REQ-009 SHALL have port: empty  output  1  FIFO holds 0 entries.
REQ-010 SHALL have port: overflow  output  1  sticky; set by a push while full.
REQ-011 SHALL have port: uart_tx  output  1  registered serial line, idle high.
REQ-012 SHALL have port: tx_busy  output  1  high when state != IDLE or empty == 0.
REQ-013 SHALL have port: tx_done  output  1  one-clk pulse at end of each stop bit.

Function
REQ-014 SHALL accept push_data into the FIFO tail when push=1 and full=0; full/empty/count SHALL update on the same edge.
REQ-015 SHALL drop push when full=1, even if a pop occurs in the same cycle, and SHALL set overflow.
REQ-016 SHALL apply a simultaneous push (not full) and pop with count unchanged and both pointers advanced; pointers SHALL wrap modulo 2**FIFO_AW.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-018 In IDLE with empty=0, the block SHALL pop the head into an 8-bit shift register, clear bit and tick counters, and go to START on the same edge.
REQ-019 In IDLE with empty=1, the block SHALL do nothing (uart_tx=1).
REQ-020 Each bit SHALL last exactly 16 b_ticks; the bit ends on the b_tick where the 4-bit tick counter equals 15.
REQ-021 START SHALL drive 0; DATA SHALL drive 8 bits LSB first; STOP SHALL drive 1 for one bit time.
REQ-022 After STOP, the block SHALL return to IDLE and pulse tx_done for one clk.
REQ-023 Back-to-back frames SHALL be separated by exactly one clk of IDLE (stop-bit high) and no extra bit time.
REQ-024 Latency: for a push at edge E0 into an empty, idle block, uart_tx SHALL be 0 after edge E2.
REQ-025 b_tick arriving in IDLE SHALL be ignored; the tick counter SHALL count only in START/DATA/PARITY/STOP.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set state=IDLE, uart_tx=1, tx_done=0, overflow=0, FIFO pointers/count=0 (empty=1, full=0), and clear counters; tx_busy SHALL be 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately; queued bytes SHALL be discarded.

Configuration
REQ-028 With `UART_TX_PARITY_EN defined, the block SHALL insert PARITY after DATA, driving XOR(data) ^ PARITY_ODD for 16 b_ticks; the frame is 11 bits.
REQ-029 Without UART_TX_PARITY_EN, the block SHALL have no PARITY state, the frame is 10 bits, and PARITY_ODD SHALL have no effect.

Verification
REQ-030 Bench SHALL cover: no macro, push 0x55 -> uart_tx 0,1,0,1,0,1,0,1,0,1 at 16 b_ticks each; one tx_done; then empty=1, tx_busy=0.
REQ-031 Bench SHALL cover: macro, PARITY_ODD=0, push 0xA5 then 0x07 -> parity bits 0 then 1; two tx_done pulses; 11-bit frames.
REQ-032 Bench SHALL cover: FIFO_AW=3, push on 10 consecutive clks starting at E0 -> 9 bytes accepted (1 in shifter + 8 in FIFO), 10th dropped, full=1, overflow=1; exactly 9 frames sent in order.
REQ-033 Bench SHALL cover: simultaneous push/pop at count=4 -> count stays 4, data order preserved.
REQ-034 Bench SHALL cover: rst asserted mid-DATA with 3 bytes queued -> next edge uart_tx=1, empty=1, overflow=0, no tx_done; idle line afterwards.
REQ-035 Bench SHALL cover: push at E0 into idle block -> uart_tx=0 after E2; back-to-back frames have 16 b_ticks plus 1 clk of high line between data bit 7 and next start.
